// File: rtl/rd_code_pack.sv
// rd_code_pack
//   Packs the serial radial-difference comparison bits from RD_calc into
//   NBITS-wide descriptor codes and presents each completed code on a
//   valid/ready output register. The first bit of a code becomes its MSB.
//
//   Optional feature macro: RD_PACK_ROTMIN_EN
//     defined   : each completed code is replaced by its minimum circular
//                 rotation (sequential search, NBITS+1 cycle latency)
//     undefined : code_o is the raw packed code, 1-cycle latency
//
//   Ports
//     clk      in   clock, rising edge
//     rst_n    in   asynchronous active-low reset
//     bit_i    in   comparison bit, valid when done_i is high
//     done_i   in   bit strobe
//     clr_i    in   synchronous clear of partial code and overflow flag
//     ready_i  in   downstream accepts code_o when valid_o && ready_i
//     code_o   out  packed (or rotation-minimised) code
//     valid_o  out  code_o holds an unconsumed code
//     ovf_o    out  sticky: a completed code was dropped
//
//   Rotation FSM (RD_PACK_ROTMIN_EN only)
//     state | meaning
//     IDLE  | waiting for a completed code
//     ROT   | rotating the captured code, tracking the minimum (NBITS-1 cycles)
//     EMIT  | waiting for the output register to be free, then load minimum

module rd_code_pack #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_i,
    input  logic             done_i,
    input  logic             clr_i,
    input  logic             ready_i,
    output logic [NBITS-1:0] code_o,
    output logic             valid_o,
    output logic             ovf_o
);

    localparam int CW = $clog2(NBITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);

    logic [NBITS-2:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NBITS-1:0] code_q, code_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic             complete;
    logic [NBITS-1:0] code_new;
    logic             load;
    logic             drop;
    logic [NBITS-1:0] load_code;

    // Bit packing; clr_i suppresses the strobe so a clear always wins
    // over a completing bit.
    always_comb begin
        complete = done_i && !clr_i && (cnt_q == CNT_LAST);
        code_new = {shift_q, bit_i};
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (done_i) begin
            shift_d = code_new[NBITS-2:0];
            cnt_d   = complete ? '0 : cnt_q + CW'(1);
        end
    end

`ifdef RD_PACK_ROTMIN_EN
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ROT  = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;
    localparam logic [CW-1:0] K_LAST = CW'(NBITS - 2);

    logic [1:0]       state_q, state_d;
    logic [NBITS-1:0] rot_q, rot_d;
    logic [NBITS-1:0] min_q, min_d;
    logic [CW-1:0]    k_q, k_d;
    logic [NBITS-1:0] rot_next;

    always_comb begin
        rot_next  = {rot_q[NBITS-2:0], rot_q[NBITS-1]};
        state_d   = state_q;
        rot_d     = rot_q;
        min_d     = min_q;
        k_d       = k_q;
        load      = 1'b0;
        load_code = min_q;
        // Only IDLE can accept a new code; anything completing otherwise is lost.
        drop      = complete && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (complete) begin
                    rot_d   = code_new;
                    min_d   = code_new;
                    k_d     = '0;
                    state_d = ST_ROT;
                end
            end
            ST_ROT: begin
                rot_d = rot_next;
                if (rot_next < min_q) begin
                    min_d = rot_next;
                end
                k_d = k_q + CW'(1);
                if (k_q == K_LAST) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (!valid_q || ready_i) begin
                    load    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rot_q   <= '0;
            min_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            min_q   <= min_d;
            k_q     <= k_d;
        end
    end
`else
    always_comb begin
        load      = complete && (!valid_q || ready_i);
        drop      = complete && !load;
        load_code = code_new;
    end
`endif

    // Output register: a load wins over a handshake, so valid_o stays high
    // with no bubble when both happen together.
    always_comb begin
        code_d  = code_q;
        valid_d = valid_q;
        if (load) begin
            code_d  = load_code;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        ovf_d = ovf_q;
        if (clr_i) begin
            ovf_d = 1'b0;
        end else if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign code_o  = code_q;
    assign valid_o = valid_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_rd_code_pack.sv
// tb_rd_code_pack
//   Self-checking bench for rd_code_pack (NBITS=8). A behavioural model
//   tracks the packed value arithmetically, the minimum rotation by brute
//   force over all rotations, and the output register as a simple pending
//   code with a countdown. Works with or without RD_PACK_ROTMIN_EN.

module tb_rd_code_pack;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         bit_i;
    logic         done_i;
    logic         clr_i;
    logic         ready_i;
    logic [N-1:0] code_o;
    logic         valid_o;
    logic         ovf_o;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int m_acc;
    int m_cnt;
    int m_code;
    bit m_valid;
    bit m_ovf;
    bit m_pend;
    int m_wait;
    int m_pcode;

    rd_code_pack #(.NBITS(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bit_i   (bit_i),
        .done_i  (done_i),
        .clr_i   (clr_i),
        .ready_i (ready_i),
        .code_o  (code_o),
        .valid_o (valid_o),
        .ovf_o   (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int min_rot(input int v);
        int m;
        int r;
        m = v;
        r = v;
        for (int i = 1; i < N; i++) begin
            r = ((r * 2) % 256) + (r / 128);
            if (r < m) m = r;
        end
        return m;
    endfunction

    task automatic model_reset();
        m_acc   = 0;
        m_cnt   = 0;
        m_code  = 0;
        m_valid = 0;
        m_ovf   = 0;
        m_pend  = 0;
        m_wait  = 0;
        m_pcode = 0;
    endtask

    task automatic model_step(input bit b, input bit d, input bit c, input bit r);
        bit complete;
        bit can;
        bit load;
        bit drop;
        bit was_pend;
        int newc;
        int lcode;
        complete = d && !c && (m_cnt == N - 1);
        newc     = ((m_acc * 2) + int'(b)) % 256;
        can      = !m_valid || r;
        load     = 0;
        drop     = 0;
        lcode    = 0;
`ifdef RD_PACK_ROTMIN_EN
        was_pend = m_pend;
        if (m_pend && m_wait == 0 && can) begin
            load   = 1;
            lcode  = m_pcode;
            m_pend = 0;
        end else if (m_pend && m_wait > 0) begin
            m_wait = m_wait - 1;
        end
        if (complete) begin
            if (!was_pend) begin
                m_pend  = 1;
                m_wait  = N - 1;
                m_pcode = min_rot(newc);
            end else begin
                drop = 1;
            end
        end
`else
        was_pend = 0;
        if (complete) begin
            if (can) begin
                load  = 1;
                lcode = newc;
            end else begin
                drop = 1;
            end
        end
`endif
        if (load) begin
            m_code  = lcode;
            m_valid = 1;
        end else if (m_valid && r) begin
            m_valid = 0;
        end
        if (c) m_ovf = 0;
        else if (drop) m_ovf = 1;
        if (c) begin
            m_acc = 0;
            m_cnt = 0;
        end else if (d) begin
            m_acc = newc;
            m_cnt = (m_cnt + 1) % N;
        end
    endtask

    task automatic step(input bit b, input bit d, input bit c, input bit r);
        @(negedge clk);
        bit_i   = b;
        done_i  = d;
        clr_i   = c;
        ready_i = r;
        @(posedge clk);
        model_step(b, d, c, r);
        #1;
    endtask

    // Sends one code MSB first on consecutive strobes; r_last is the ready
    // value during the final strobe.
    task automatic send_code(input int v, input bit r_body, input bit r_last);
        for (int i = N - 1; i >= 0; i--) begin
            step(bit'((v >> i) & 1), 1'b1, 1'b0, (i == 0) ? r_last : r_body);
        end
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, r);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bit_i   = 1'b0;
        done_i  = 1'b0;
        clr_i   = 1'b0;
        ready_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({code_o, valid_o, ovf_o} !== 10'd0)
            $display("FAIL reset_outputs: got code=%h valid=%b ovf=%b, want all 0", code_o, valid_o, ovf_o);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 1'b0);
        n_checks++;
        if ({code_o, valid_o, ovf_o} !== {m_code[7:0], m_valid, m_ovf})
            $display("FAIL reset_idle: got %h/%b/%b, want %h/%b/%b", code_o, valid_o, ovf_o, m_code[7:0], m_valid, m_ovf);
        else n_pass++;
    endtask

    task automatic test_raw_pack();
        logic [7:0] exp_code;
        send_code(32'h90, 1'b1, 1'b1);
`ifdef RD_PACK_ROTMIN_EN
        exp_code = 8'h09;
        idle(7, 1'b1);
        n_checks++;
        if (valid_o !== 1'b0)
            $display("FAIL rot_latency_early: valid=%b, want 0 before cycle N+1", valid_o);
        else n_pass++;
        step(1'b0, 1'b0, 1'b0, 1'b1);
`else
        exp_code = 8'h90;
`endif
        n_checks++;
        if (valid_o !== 1'b1 || code_o !== exp_code)
            $display("FAIL pack_code: got code=%h valid=%b, want code=%h valid=1", code_o, valid_o, exp_code);
        else n_pass++;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (valid_o !== 1'b0 || code_o !== exp_code)
            $display("FAIL pack_handshake: got code=%h valid=%b, want code=%h valid=0", code_o, valid_o, exp_code);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_code;
        send_code(32'h90, 1'b0, 1'b0);
        send_code(32'h0F, 1'b0, 1'b0);
        idle(3, 1'b0);
`ifdef RD_PACK_ROTMIN_EN
        exp_code = 8'h09;
`else
        exp_code = 8'h90;
`endif
        n_checks++;
        if (code_o !== exp_code || valid_o !== 1'b1 || ovf_o !== 1'b1)
            $display("FAIL backpressure_ovf: got code=%h valid=%b ovf=%b, want %h/1/1", code_o, valid_o, ovf_o, exp_code);
        else n_pass++;
        n_checks++;
        if ({code_o, valid_o, ovf_o} !== {m_code[7:0], m_valid, m_ovf})
            $display("FAIL backpressure_model: got %h/%b/%b, want %h/%b/%b", code_o, valid_o, ovf_o, m_code[7:0], m_valid, m_ovf);
        else n_pass++;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (ovf_o !== 1'b0 || valid_o !== 1'b1 || code_o !== exp_code)
            $display("FAIL clr_ovf: got code=%h valid=%b ovf=%b, want %h/1/0", code_o, valid_o, ovf_o, exp_code);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (valid_o !== 1'b0)
            $display("FAIL b2b_drain: valid=%b, want 0", valid_o);
        else n_pass++;
        send_code(32'hAA, 1'b0, 1'b0);
        idle(10, 1'b0);
        n_checks++;
        if (valid_o !== 1'b1 || code_o !== m_code[7:0])
            $display("FAIL b2b_first: got code=%h valid=%b, want %h/1", code_o, valid_o, m_code[7:0]);
        else n_pass++;
        send_code(32'h55, 1'b0, 1'b1);
`ifndef RD_PACK_ROTMIN_EN
        n_checks++;
        if (code_o !== 8'h55 || valid_o !== 1'b1)
            $display("FAIL b2b_load_handshake: got code=%h valid=%b, want 55/1", code_o, valid_o);
        else n_pass++;
`endif
        n_checks++;
        if ({code_o, valid_o, ovf_o} !== {m_code[7:0], m_valid, m_ovf})
            $display("FAIL b2b_model: got %h/%b/%b, want %h/%b/%b", code_o, valid_o, ovf_o, m_code[7:0], m_valid, m_ovf);
        else n_pass++;
        idle(12, 1'b1);
    endtask

    task automatic test_clr_mid();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        send_code(32'h0F, 1'b1, 1'b0);
        idle(10, 1'b0);
        n_checks++;
        if (code_o !== 8'h0F || valid_o !== 1'b1 || ovf_o !== 1'b0)
            $display("FAIL clr_mid_code: got code=%h valid=%b ovf=%b, want 0f/1/0", code_o, valid_o, ovf_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        done_i = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({code_o, valid_o, ovf_o} !== 10'd0)
            $display("FAIL reset_async: got code=%h valid=%b ovf=%b, want all 0", code_o, valid_o, ovf_o);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        send_code(32'hC3, 1'b0, 1'b0);
        idle(10, 1'b0);
        n_checks++;
        if (code_o !== min_rot(32'hC3) && code_o !== 8'hC3)
            $display("FAIL reset_fresh_code: got code=%h, want fresh code from C3", code_o);
        else n_pass++;
        n_checks++;
        if ({code_o, valid_o, ovf_o} !== {m_code[7:0], m_valid, m_ovf})
            $display("FAIL reset_fresh_model: got %h/%b/%b, want %h/%b/%b", code_o, valid_o, ovf_o, m_code[7:0], m_valid, m_ovf);
        else n_pass++;
    endtask

    task automatic test_random();
        bit b, d, c, r;
        for (int i = 0; i < 400; i++) begin
            b = bit'($urandom_range(0, 1));
            d = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 31) == 0);
            r = bit'($urandom_range(0, 1));
            step(b, d, c, r);
            n_checks++;
            if ({code_o, valid_o, ovf_o} !== {m_code[7:0], m_valid, m_ovf})
                $display("FAIL random_cycle_%0d: got %h/%b/%b, want %h/%b/%b",
                         i, code_o, valid_o, ovf_o, m_code[7:0], m_valid, m_ovf);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_raw_pack();
        test_backpressure();
        test_back_to_back();
        test_clr_mid();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rd_code_pack.md
# rd_code_pack

Packs the serial radial-difference bit stream from the NIRD `RD_calc` stage into NBITS-wide descriptor codes. Each `done_i` strobe captures one comparison bit. After NBITS bits, the completed code is presented on a valid/ready output register for the histogram/feature stage downstream. An optional sequential search replaces each code with its minimum circular rotation before output, giving a rotation-invariant descriptor.

## Interface
- NBITS, 8, bits per code (legal 2..32)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- bit_i  in  1  RD comparison bit (from `RD_calc` `bit_o`)
- done_i  in  1  bit strobe; bit_i valid when high (from `RD_calc` `done_o`)
- clr_i  in  1  synchronous clear of the partial code and overflow flag
- ready_i  in  1  downstream accepts code_o when valid_o && ready_i
- code_o  out  NBITS  packed code
- valid_o  out  1  code_o holds an unconsumed code
- ovf_o  out  1  sticky: a completed code was dropped

## Operation
- Reset: every output and every internal register (shift, cnt, state, rot, min, k) is 0.
- Packing:
  - On each edge with done_i=1, shift <= {shift[NBITS-2:0], bit_i} and cnt increments. The first bit of a code ends up as the MSB.
  - When done_i=1 and cnt==NBITS-1, the code is complete. The completed value is {shift[NBITS-2:0], bit_i} and cnt returns to 0. Bits continue to be accepted every cycle with no gap.
- clr_i=1:
  - Clears shift, cnt and ovf_o, and ignores done_i in that cycle.
  - Does not touch the output register or a rotation in progress.
- Output register:
  - A load sets code_o and raises valid_o.
  - A handshake (valid_o && ready_i) with no simultaneous load clears valid_o. code_o holds its last value.
  - A load in the same cycle as a handshake replaces the code, and valid_o stays 1.
- Without the macro:
  - A completed code loads into the output register if !valid_o || ready_i.
  - Otherwise the code is dropped and ovf_o is set to 1. ovf_o stays set until clr_i or reset.

## Timing
- Without the macro: code_o/valid_o update at the edge ending the cycle of the final done_i. Latency is 1 cycle.
- With the macro: FSM with states IDLE, ROT and EMIT.
  - IDLE: on code completion, rot <= code, min <= code, k <= 0, then go to ROT.
  - ROT: each cycle, rot <= rotl(rot,1) and min <= min(min, rotl(rot,1)) as an unsigned compare, then k++.
  - Leave ROT for EMIT after the cycle with k==NBITS-2, so ROT lasts exactly NBITS-1 cycles.
  - EMIT: if !valid_o || ready_i, load min into the output register and go to IDLE. Otherwise stay in EMIT.
  - Final bit in cycle 0 gives valid_o=1 in cycle NBITS+1 when the output is free.
  - A code completing while the FSM is not IDLE is dropped and ovf_o is set. Packing of later bits continues.
- Reset asserted mid-code or mid-rotation returns everything to 0 immediately. There is no partial output.
- A clr_i in the same cycle as a completing done_i wins: no code is produced.

## Configuration
- RD_PACK_ROTMIN_EN:
  - Defined: the ROT/EMIT FSM is compiled in, and code_o is the minimum circular rotation of the packed code.
  - Undefined: the FSM, rot, min and k are absent, and code_o is the raw packed code with 1-cycle latency.

## Test plan
All scenarios use NBITS=8.
- Raw pack, macro off:
  - Stimulus: bits 1,0,0,1,0,0,0,0 on consecutive done_i, ready_i=1.
  - Response: code_o=0x90 and valid_o=1 exactly one cycle after the 8th strobe. valid_o drops the next cycle.
- Back-pressure and overflow, macro off:
  - Stimulus: ready_i=0, then two full codes 0x90 and 0x0F.
  - Response: code_o stays 0x90 and ovf_o=1 after the second code.
  - Then clr_i=1: ovf_o=0 while valid_o stays 1.
- Simultaneous load and handshake:
  - Stimulus: valid_o=1 with 0xAA, and ready_i=1 in the same cycle a new code 0x55 completes.
  - Response: code_o=0x55 and valid_o stays 1 with no gap.
- Rotation minimum, macro on:
  - Stimulus: bits for 0x90.
  - Response: code_o=0x09 and valid_o rises exactly 9 cycles after the final strobe.
  - A second code completing during ROT is dropped and ovf_o=1.
- clr_i and reset mid-code:
  - Stimulus: 5 bits, then clr_i, then bits for 0x0F.
  - Response: code_o=0x0F.
  - Separately, rst_n low after 3 bits clears all outputs asynchronously, and the next 8 bits form a fresh code.
